// File: rtl/ex_branch_ctrl.sv
// ---------------------------------------------------------------------------
// ex_branch_ctrl
//
// EX-stage controller that sits on the far side of the ALU interface.
//  - Decodes the EX opcode into one-hot ALU controls (add/inc/neg/sub).
//  - Captures the ALU Z/N results of ALU instructions into committed flags.
//  - Resolves J / JM / BRZ / BRN against the committed flags and pulses
//    redirect (plus redirect_mem for JM, whose target comes from memory).
//  - Squashes the wrong-path instructions that enter EX after a redirect.
//
// Handshake / flow semantics:
//  There is no valid/ready pair here. id_valid qualifies id_opcode.
//  stall=1 freezes every register in this block (only rst overrides it).
//  redirect is suppressed while stall=1, so a taken transfer pulses exactly
//  once: on the cycle EX actually advances.
//
// Ports:
//  clk, rst                 rising-edge clock, synchronous active-high reset
//  id_valid, id_opcode      instruction presented by the ID/EX register
//  stall                    hold the EX stage
//  alu_z, alu_n             ALU flags for the instruction currently in EX
//  alu_add/inc/neg/sub      one-hot ALU controls, combinational from EX
//  flag_z, flag_n           committed flags
//  redirect, redirect_mem   taken control transfer in EX (mem target for JM)
//  ex_valid                 EX holds a live, non-squashed instruction
// ---------------------------------------------------------------------------
module ex_branch_ctrl #(
  parameter int unsigned SQUASH_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_opcode,
  input  logic       stall,
  input  logic       alu_z,
  input  logic       alu_n,
  output logic       alu_add,
  output logic       alu_inc,
  output logic       alu_neg,
  output logic       alu_sub,
  output logic       flag_z,
  output logic       flag_n,
  output logic       redirect,
  output logic       redirect_mem,
  output logic       ex_valid
);

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_INC = 4'b0101;
  localparam logic [3:0] OP_NEG = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b0111;
  localparam logic [3:0] OP_J   = 4'b1000;
  localparam logic [3:0] OP_BRZ = 4'b1001;
  localparam logic [3:0] OP_JM  = 4'b1010;
  localparam logic [3:0] OP_BRN = 4'b1011;

  // Squash count reload values. When the slot captured on the redirect edge
  // holds a real instruction it is the first squashed one, so DEPTH-1 remain.
  // When it is a bubble nothing wrong-path has been consumed yet, so the full
  // DEPTH remain; this keeps the count in units of valid instructions.
  localparam logic [2:0] SQ_AFTER_VALID  = 3'(SQUASH_DEPTH - 1);
  localparam logic [2:0] SQ_AFTER_BUBBLE = 3'(SQUASH_DEPTH);

  logic [3:0] ex_opcode;
  logic [2:0] squash_cnt;

  logic is_alu_op;
  logic taken;
  logic squash;

  // ALU opcodes are 01xx.
  assign is_alu_op = (ex_opcode[3:2] == 2'b01);

  assign alu_add = ex_valid & (ex_opcode == OP_ADD);
  assign alu_inc = ex_valid & (ex_opcode == OP_INC);
  assign alu_neg = ex_valid & (ex_opcode == OP_NEG);
  assign alu_sub = ex_valid & (ex_opcode == OP_SUB);

  // Branches read the committed flags: the ALU op directly ahead of the
  // branch wrote them on the previous edge, so no forwarding is needed.
  assign taken = ex_valid & ((ex_opcode == OP_J) |
                             (ex_opcode == OP_JM) |
                             ((ex_opcode == OP_BRZ) & flag_z) |
                             ((ex_opcode == OP_BRN) & flag_n));

  assign redirect     = taken & ~stall;
  assign redirect_mem = redirect & (ex_opcode == OP_JM);

  assign squash = redirect | (squash_cnt != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_opcode  <= 4'b0000;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      squash_cnt <= 3'd0;
    end else if (!stall) begin
      ex_opcode <= id_opcode;
      ex_valid  <= id_valid & ~squash;

      if (ex_valid && is_alu_op) begin
        flag_z <= alu_z;
        flag_n <= alu_n;
      end

      if (redirect) begin
        squash_cnt <= id_valid ? SQ_AFTER_VALID : SQ_AFTER_BUBBLE;
      end else if (id_valid && (squash_cnt != 3'd0)) begin
        squash_cnt <= squash_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ex_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_branch_ctrl
//
// Table of per-cycle vectors {rst, id_valid, id_opcode, stall, alu_z, alu_n,
// expected outputs}. Expected outputs describe what the DUT shows during the
// cycle the inputs are applied (before the next rising edge). Expected bit
// order: {alu_add, alu_inc, alu_neg, alu_sub, flag_z, flag_n, redirect,
// redirect_mem, ex_valid}. A short random ALU-op sequence with a tiny flag
// model follows the table.
// ---------------------------------------------------------------------------
module tb_ex_branch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic       stall;
  logic       alu_z;
  logic       alu_n;
  logic       alu_add, alu_inc, alu_neg, alu_sub;
  logic       flag_z, flag_n;
  logic       redirect, redirect_mem, ex_valid;

  always #5 clk = ~clk;

  ex_branch_ctrl #(.SQUASH_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .stall        (stall),
    .alu_z        (alu_z),
    .alu_n        (alu_n),
    .alu_add      (alu_add),
    .alu_inc      (alu_inc),
    .alu_neg      (alu_neg),
    .alu_sub      (alu_sub),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .redirect     (redirect),
    .redirect_mem (redirect_mem),
    .ex_valid     (ex_valid)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [3:0] op;
    logic       stall;
    logic       z;
    logic       n;
    logic [8:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] op,
                              input logic s, input logic z, input logic n,
                              input logic [8:0] e);
    vec_t t;
    t.rst = r; t.v = v; t.op = op; t.stall = s; t.z = z; t.n = n; t.exp = e;
    return t;
  endfunction

  // Expected-output packer: alu one-hot, flags, redirect, redirect_mem, ex_valid.
  function automatic logic [8:0] e(input logic [3:0] alu, input logic fz,
                                   input logic fn, input logic rd,
                                   input logic rm, input logic ev);
    return {alu, fz, fn, rd, rm, ev};
  endfunction

  // Drive one cycle's inputs just after the falling edge, record the
  // expectation, then sample mid-low-phase, well away from the rising edge.
  task automatic step(input vec_t t, input string name);
    logic [8:0] act;
    logic [8:0] want;
    @(negedge clk);
    rst       = t.rst;
    id_valid  = t.v;
    id_opcode = t.op;
    stall     = t.stall;
    alu_z     = t.z;
    alu_n     = t.n;
    exp_q.push_back(t.exp);
    #2;
    act  = {alu_add, alu_inc, alu_neg, alu_sub, flag_z, flag_n,
            redirect, redirect_mem, ex_valid};
    want = exp_q.pop_front();
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b (add inc neg sub fz fn rd rm ev)",
               name, act, want);
    end
  endtask

  localparam logic [3:0] NOP = 4'h0, ADD = 4'h4, INC = 4'h5, NEG = 4'h6,
                         SUB = 4'h7, J = 4'h8, BRZ = 4'h9, JM = 4'hA,
                         BRN = 4'hB, LD = 4'hE, BAD = 4'h1;
  localparam logic [3:0] A0 = 4'b0000, AADD = 4'b1000, AINC = 4'b0100,
                         ANEG = 4'b0010, ASUB = 4'b0001;

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_opcode = 4'h0; stall = 1'b0;
    alu_z = 1'b0; alu_n = 1'b0;

    // Reset, with stall asserted to show rst wins; outputs observed after
    // the first reset edge must all be 0.
    @(negedge clk);
    stall = 1'b1;
    step(mk(1, 0, NOP, 1, 0, 0, e(A0, 0, 0, 0, 0, 0)), "reset_state");

    // 1. ALU decode, then LD must not touch flags.
    vecs.push_back(mk(0, 1, ADD, 0, 0, 0, e(A0,   0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, INC, 0, 1, 0, e(AADD, 0, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 1, NEG, 0, 0, 1, e(AINC, 1, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 1, SUB, 0, 1, 1, e(ANEG, 0, 1, 0, 0, 1)));
    vecs.push_back(mk(0, 1, LD,  0, 0, 0, e(ASUB, 1, 1, 0, 0, 1)));
    vecs.push_back(mk(0, 0, NOP, 0, 1, 1, e(A0,   0, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 0, NOP, 0, 1, 1, e(A0,   0, 0, 0, 0, 0)));
    // 2. SUB z=1 then BRZ taken; two valid wrong-path squashed, third live.
    vecs.push_back(mk(0, 1, SUB, 0, 0, 0, e(A0,   0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, BRZ, 0, 1, 0, e(ASUB, 0, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 1, NOP, 0, 0, 0, e(A0,   1, 0, 1, 0, 1)));
    vecs.push_back(mk(0, 1, NOP, 0, 0, 0, e(A0,   1, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, NOP, 0, 0, 0, e(A0,   1, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, NOP, 0, 0, 0, e(A0,   1, 0, 0, 0, 1)));
    // 3. ADD n=1, BRZ not taken, BRN taken.
    vecs.push_back(mk(0, 1, ADD, 0, 0, 0, e(A0,   1, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, BRZ, 0, 0, 1, e(AADD, 1, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 1, BRN, 0, 0, 0, e(A0,   0, 1, 0, 0, 1)));
    vecs.push_back(mk(0, 1, BAD, 0, 0, 0, e(A0,   0, 1, 1, 0, 1)));
    vecs.push_back(mk(0, 1, NOP, 0, 0, 0, e(A0,   0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 0, NOP, 0, 0, 0, e(A0,   0, 1, 0, 0, 0)));
    // 4. JM held by a 3-cycle stall, single redirect pulse on release.
    vecs.push_back(mk(0, 1, JM,  0, 0, 0, e(A0,   0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, NOP, 1, 1, 0, e(A0,   0, 1, 0, 0, 1)));
    vecs.push_back(mk(0, 1, NOP, 1, 1, 0, e(A0,   0, 1, 0, 0, 1)));
    vecs.push_back(mk(0, 1, NOP, 1, 1, 0, e(A0,   0, 1, 0, 0, 1)));
    vecs.push_back(mk(0, 1, NOP, 0, 1, 0, e(A0,   0, 1, 1, 1, 1)));
    vecs.push_back(mk(0, 1, NOP, 0, 0, 0, e(A0,   0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 0, NOP, 0, 0, 0, e(A0,   0, 1, 0, 0, 0)));
    // 5. J, two bubbles (not counted), three NOPs: first two squashed.
    vecs.push_back(mk(0, 1, J,   0, 0, 0, e(A0,   0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 0, NOP, 0, 0, 0, e(A0,   0, 1, 1, 0, 1)));
    vecs.push_back(mk(0, 0, NOP, 0, 0, 0, e(A0,   0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, NOP, 0, 0, 0, e(A0,   0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, NOP, 0, 0, 0, e(A0,   0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, NOP, 0, 0, 0, e(A0,   0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 0, NOP, 0, 0, 0, e(A0,   0, 1, 0, 0, 1)));
    // 6. J then reset on the redirect edge; first ADD afterwards is live.
    vecs.push_back(mk(0, 1, J,   0, 0, 0, e(A0,   0, 1, 0, 0, 0)));
    vecs.push_back(mk(1, 1, NOP, 0, 0, 0, e(A0,   0, 1, 1, 0, 1)));
    vecs.push_back(mk(0, 1, ADD, 0, 0, 0, e(A0,   0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, NOP, 0, 0, 0, e(AADD, 0, 0, 0, 0, 1)));
    // Stall over an ALU op: flags must hold until EX advances.
    vecs.push_back(mk(0, 1, INC, 0, 0, 0, e(A0,   0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, NOP, 1, 1, 1, e(AINC, 0, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 1, NOP, 0, 0, 1, e(AINC, 0, 0, 0, 0, 1)));
    vecs.push_back(mk(0, 0, NOP, 0, 0, 0, e(A0,   0, 1, 0, 0, 1)));

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Random back-to-back ALU ops: each cycle's flags are the previous
    // cycle's ALU results. EX is empty entering this sequence; flags are 0,1.
    begin
      logic       prev_valid;
      logic [3:0] prev_op;
      logic       mz, mn;
      prev_valid = 1'b0; prev_op = NOP; mz = 1'b0; mn = 1'b1;
      for (int i = 0; i < 10; i++) begin
        logic [3:0] op;
        logic       z, n;
        logic [3:0] oh;
        op = 4'($urandom_range(4, 7));
        z  = 1'($urandom_range(0, 1));
        n  = 1'($urandom_range(0, 1));
        oh = prev_valid ? (4'b1000 >> (prev_op - 4'd4)) : 4'b0000;
        step(mk(0, 1, op, 0, z, n, e(oh, mz, mn, 0, 0, prev_valid)),
             $sformatf("rand%0d", i));
        if (prev_valid) begin
          mz = z;
          mn = n;
        end
        prev_valid = 1'b1;
        prev_op    = op;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
